// File: rtl/bank_readout_ctrl_if.sv
// Readout bus bundle: bank-memory read port plus the valid/ready output stream.
// The master side is the readout controller; the slave side is the memory and consumer.
interface bank_readout_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int ABITS = 5,
  parameter int BBITS = 1
);
  logic             rd_en_o;
  logic [BBITS-1:0] rd_bank_o;
  logic [ABITS-1:0] rd_adr_o;
  logic [WIDTH-1:0] rd_dat_i;
  logic [WIDTH-1:0] dat_o;
  logic             valid_o;
  logic             last_o;
  logic             ready_i;

  modport master (
    output rd_en_o, rd_bank_o, rd_adr_o, dat_o, valid_o, last_o,
    input  rd_dat_i, ready_i
  );

  modport slave (
    input  rd_en_o, rd_bank_o, rd_adr_o, dat_o, valid_o, last_o,
    output rd_dat_i, ready_i
  );
endinterface

// File: rtl/bank_readout_ctrl.sv
// Bank readout controller: on a bank swap, reads every word of the retired
// correlator bank and streams it out through a small credit-limited FIFO.
module bank_readout_ctrl #(
  parameter int WIDTH   = 32,
  parameter int ABITS   = 5,
  parameter int NBLOCKS = 24,
  parameter int BANKS   = 2,
  parameter int BBITS   = 1,
  parameter int RLAT    = 2,
  parameter int FDEPTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                swap_i,
  input  logic                clr_i,
  output logic [BBITS-1:0]    wbank_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o,
  bank_readout_ctrl_if.master bus
);

  localparam int PBITS = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CBITS = $clog2(FDEPTH + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [BBITS-1:0]     wbank_q, rd_bank_q;
  logic [ABITS-1:0]     adr_q;
  logic                 overrun_q;
  logic [RLAT-1:0]      vld_q, vld_d, lst_q, lst_d;
  logic [CBITS-1:0]     inflight_q, count_q;
  logic [PBITS-1:0]     wptr_q, rptr_q;
  logic [WIDTH:0]       fifo_q [FDEPTH];

  logic                 start, rd_en, issue_last, credit_ok, tap, pop;
  logic [CBITS:0]       used;

  // A swap only launches a readout from IDLE or DONE; elsewhere it is an overrun.
  assign start      = swap_i && en_i && (state_q == IDLE || state_q == DONE);
  assign issue_last = (adr_q == ABITS'(NBLOCKS - 1));
  // Reserve a FIFO slot for every read in flight so no return can be dropped.
  assign used       = {1'b0, count_q} + {1'b0, inflight_q};
  assign credit_ok  = (used < (CBITS + 1)'(FDEPTH));
  assign tap        = vld_q[RLAT-1];
  assign pop        = bus.valid_o && bus.ready_i;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (rd_en && issue_last) state_d = DRAIN;
      DRAIN:   if (inflight_q == '0 && count_q == '0) state_d = DONE;
      DONE:    state_d = start ? READ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: read strobe is throttled by FIFO credit.
  always_comb begin
    rd_en  = 1'b0;
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
    if (state_q == READ) rd_en = credit_ok;
  end

  // Bank pointers, read address and sticky overrun flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbank_q   <= '0;
      rd_bank_q <= '0;
      adr_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (swap_i) wbank_q <= wbank_q + BBITS'(1);
      if (start) begin
        rd_bank_q <= wbank_q;
        adr_q     <= '0;
      end else if (rd_en) begin
        adr_q <= adr_q + ABITS'(1);
      end
      if (swap_i && (state_q == READ || state_q == DRAIN)) overrun_q <= 1'b1;
      else if (clr_i)                                       overrun_q <= 1'b0;
    end
  end

  // Read-latency shift: valid and last flag ride alongside each issued read.
  always_comb begin
    vld_d    = '0;
    lst_d    = '0;
    vld_d[0] = rd_en;
    lst_d[0] = rd_en && issue_last;
    for (int i = 1; i < RLAT; i++) begin
      vld_d[i] = vld_q[i-1];
      lst_d[i] = lst_q[i-1];
    end
  end

  // Read pipeline and in-flight counter; reset discards pending returns.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q      <= '0;
      lst_q      <= '0;
      inflight_q <= '0;
    end else begin
      vld_q <= vld_d;
      lst_q <= lst_d;
      if (rd_en && !tap)      inflight_q <= inflight_q + CBITS'(1);
      else if (!rd_en && tap) inflight_q <= inflight_q - CBITS'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (tap) wptr_q <= (wptr_q == PBITS'(FDEPTH - 1)) ? '0 : wptr_q + PBITS'(1);
      if (pop) rptr_q <= (rptr_q == PBITS'(FDEPTH - 1)) ? '0 : rptr_q + PBITS'(1);
      if (tap && !pop)      count_q <= count_q + CBITS'(1);
      else if (!tap && pop) count_q <= count_q - CBITS'(1);
    end
  end

  // FIFO storage: data words carry their last flag in the top bit.
  always_ff @(posedge clk_i) begin
    if (tap) fifo_q[wptr_q] <= {lst_q[RLAT-1], bus.rd_dat_i};
  end

  // Head of the FIFO is forced to zero when empty so idle outputs read as 0.
  assign bus.valid_o   = (count_q != '0);
  assign bus.dat_o     = bus.valid_o ? fifo_q[rptr_q][WIDTH-1:0] : '0;
  assign bus.last_o    = bus.valid_o && fifo_q[rptr_q][WIDTH];
  assign bus.rd_en_o   = rd_en;
  assign bus.rd_bank_o = rd_bank_q;
  assign bus.rd_adr_o  = adr_q;
  assign wbank_o       = wbank_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_bank_readout_ctrl.sv
// Bench for bank_readout_ctrl: memory model, scoreboard queue fed at swap time,
// and a monitor that pops and compares every accepted output word.
module tb_bank_readout_ctrl;
  localparam int W = 32, A = 5, NB = 8, NBK = 2, BB = 1, RL = 2, FD = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni, en_i, swap_i, clr_i;
  logic [BB-1:0] wbank_o;
  logic busy_o, done_o, overrun_o;

  bank_readout_ctrl_if #(.WIDTH(W), .ABITS(A), .BBITS(BB)) bus ();

  bank_readout_ctrl #(
    .WIDTH(W), .ABITS(A), .NBLOCKS(NB), .BANKS(NBK), .BBITS(BB), .RLAT(RL), .FDEPTH(FD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .swap_i(swap_i), .clr_i(clr_i),
    .wbank_o(wbank_o), .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, last_pop_cyc = -100;
  int rmode = 0;
  int m_wbank = 0, m_rdbank = 0, m_next_adr = 0, done_pending = 0;
  bit m_ovr = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  bit prev_stall = 0;
  logic [W-1:0] prev_dat;
  logic prev_last;

  logic [W-1:0] mem [NBK][NB];
  logic [W-1:0] rpipe [RL];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bank memory with RL-cycle read latency; junk when not reading.
  always @(posedge clk) begin
    if (bus.rd_en_o && int'(bus.rd_adr_o) < NB)
      rpipe[0] <= mem[int'(bus.rd_bank_o)][int'(bus.rd_adr_o)];
    else
      rpipe[0] <= $urandom;
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bus.rd_dat_i = rpipe[RL-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fill_mem();
    for (int b = 0; b < NBK; b++)
      for (int i = 0; i < NB; i++) mem[b][i] = $urandom;
  endtask

  task automatic model_start(input int b);
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      e.d = mem[b][i];
      e.l = (i == NB - 1);
      exp_q.push_back(e);
    end
    done_pending++;
    m_rdbank = b;
    m_next_adr = 0;
  endtask

  // One stimulus cycle, entered and left at posedge+1.
  task automatic step(input bit sw, input bit en, input bit clr);
    bit busy_m;
    busy_m = (exp_q.size() != 0);
    swap_i = sw; en_i = en; clr_i = clr;
    if (sw) begin
      if (busy_m) m_ovr = 1'b1;
      else if (en) model_start(m_wbank);
      m_wbank = (m_wbank + 1) % NBK;
    end
    if (clr && !(sw && busy_m)) m_ovr = 1'b0;
    @(posedge clk); #1;
    swap_i = 1'b0; clr_i = 1'b0;
    chk("wbank", 64'(wbank_o), 64'(m_wbank));
    chk("overrun", 64'(overrun_o), 64'(m_ovr));
    chk("rd_bank", 64'(bus.rd_bank_o), 64'(m_rdbank));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || done_pending != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("readout_completes", 64'(exp_q.size() == 0 && done_pending == 0), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_adr(input int a);
    int n = 0;
    while (!(bus.rd_en_o && int'(bus.rd_adr_o) == a) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_adr", 64'(bus.rd_en_o && int'(bus.rd_adr_o) == a), 64'(1));
  endtask

  task automatic check_zero(input string name);
    chk(name, 64'({wbank_o, bus.rd_en_o, bus.rd_bank_o, bus.rd_adr_o, bus.dat_o,
                   bus.valid_o, bus.last_o, busy_o, done_o, overrun_o}), 64'(0));
  endtask

  // Consumer ready pattern.
  initial begin
    bus.ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       bus.ready_i = 1'b1;
        1:       bus.ready_i = (cyc % 3 == 0);
        2:       bus.ready_i = $urandom_range(0, 1) == 1;
        default: bus.ready_i = $urandom_range(0, 3) != 0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted word and checks issue order.
  initial forever begin
    @(negedge clk);
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("valid_held", 64'(bus.valid_o), 64'(1));
        chk("dat_stable", 64'(bus.dat_o), 64'(prev_dat));
        chk("last_stable", 64'(bus.last_o), 64'(prev_last));
      end
      if (bus.valid_o && bus.ready_i) begin
        chk("word_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("dat", 64'(bus.dat_o), 64'(mon_e.d));
          chk("last", 64'(bus.last_o), 64'(mon_e.l));
          if (mon_e.l) last_pop_cyc = cyc;
        end
      end
      prev_stall = bus.valid_o && !bus.ready_i;
      prev_dat   = bus.dat_o;
      prev_last  = bus.last_o;
      if (bus.rd_en_o) begin
        chk("rd_adr_range", 64'(int'(bus.rd_adr_o) < NB), 64'(1));
        chk("rd_adr_order", 64'(bus.rd_adr_o), 64'(m_next_adr));
        chk("rd_bank_issue", 64'(bus.rd_bank_o), 64'(m_rdbank));
        m_next_adr++;
      end
      if (done_o) begin
        chk("done_expected", 64'(done_pending > 0), 64'(1));
        chk("done_timing", 64'(cyc), 64'(last_pop_cyc + 2));
        if (done_pending > 0) done_pending--;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt;
    rst_ni = 1'b0; en_i = 1'b0; swap_i = 1'b0; clr_i = 1'b0;
    fill_mem();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Basic readout with ready held high, plus first-word latency.
    rmode = 0;
    step(1'b1, 1'b1, 1'b0);
    n = 0;
    while (!bus.valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("first_valid_latency", 64'(n), 64'(RL + 2));
    @(posedge clk); #1;
    wait_idle();

    // Ready asserted one cycle in three.
    rmode = 1;
    fill_mem();
    step(1'b1, 1'b1, 1'b0);
    wait_idle();

    // Swap mid-readout at address 3 flags overrun; readout continues.
    rmode = 0;
    step(1'b1, 1'b1, 1'b0);
    wait_adr(3);
    step(1'b1, 1'b1, 1'b0);
    wait_idle();
    step(1'b0, 1'b1, 1'b1);

    // Swap landing on the done pulse starts the next readout directly.
    step(1'b1, 1'b1, 1'b0);
    n = 0;
    while (!done_o && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 64'(done_o), 64'(1));
    step(1'b1, 1'b1, 1'b0);
    wait_idle();

    // Enable low: swaps only move the write pointer.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.rd_en_o || bus.valid_o) cnt++;
    end
    @(posedge clk); #1;
    chk("disabled_no_activity", 64'(cnt), 64'(0));

    // Randomized readouts: random ready, overrun swaps, clears, enable drops.
    for (int r = 0; r < 6; r++) begin
      rmode = $urandom_range(1, 3);
      fill_mem();
      step(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 30; k++) begin
        case ($urandom_range(0, 9))
          0:       if (exp_q.size() > 0) step(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                   else step(1'b0, en_i, 1'b0);
          1:       step(1'b0, 1'b1, 1'b1);
          2:       step(1'b0, 1'b0, 1'b0);
          default: step(1'b0, en_i, 1'b0);
        endcase
      end
      wait_idle();
    end

    // Reset while reading address 5 with reads in flight and overrun set.
    rmode = 0;
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    wait_adr(5);
    rst_ni = 1'b0;
    #1;
    check_zero("async_reset_outputs");
    exp_q.delete();
    done_pending = 0;
    m_wbank = 0; m_rdbank = 0; m_ovr = 1'b0; m_next_adr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.valid_o || bus.rd_en_o || busy_o) cnt++;
    end
    @(posedge clk); #1;
    chk("no_stale_after_reset", 64'(cnt), 64'(0));
    chk("wbank_after_reset", 64'(wbank_o), 64'(m_wbank));

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
